// File: rtl/nanosoc_exp_pkg.sv
// -----------------------------------------------------------------------------
// nanosoc_exp_pkg
// Shared definitions for the nanosoc expansion-region DMA initiator:
//   - AHB-Lite encodings used by the initiator (HTRANS, HSIZE, HBURST)
//   - DMA FSM state encoding
//   - word stride used when advancing source/destination addresses
// No ports (package).
// -----------------------------------------------------------------------------
package nanosoc_exp_pkg;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;
  localparam logic [31:0] WORD_STRIDE   = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_RD_ADDR  = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_WR_ADDR  = 3'd4,
    ST_WR_DATA  = 3'd5,
    ST_FINISH   = 3'd6
  } dma_state_t;

  // Clears the byte-offset bits so every access is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/nanosoc_exp_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// nanosoc_exp_dma_addr_gen
// Holds the running source/destination addresses and the remaining word count
// of the current DMA job.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   load_i             : latch a new job (addresses word aligned, fixed flags,
//                        count)
//   step_i             : one word finished; advance addresses, decrement count
//   src_addr_i/dst_addr_i, src_fixed_i/dst_fixed_i, count_i : job parameters
//   cur_src_o/cur_dst_o: addresses for the current word
//   last_o             : the current word is the final one of the job
// -----------------------------------------------------------------------------
module nanosoc_exp_dma_addr_gen
  import nanosoc_exp_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic                 src_fixed_i,
  input  logic                 dst_fixed_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  output logic [31:0]          cur_src_o,
  output logic [31:0]          cur_dst_o,
  output logic                 last_o
);

  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 src_fixed_q, src_fixed_d;
  logic                 dst_fixed_q, dst_fixed_d;

  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    src_fixed_d = src_fixed_q;
    dst_fixed_d = dst_fixed_q;
    if (load_i) begin
      src_d       = word_align(src_addr_i);
      dst_d       = word_align(dst_addr_i);
      remaining_d = count_i;
      src_fixed_d = src_fixed_i;
      dst_fixed_d = dst_fixed_i;
    end else if (step_i) begin
      // Address arithmetic wraps naturally at 32 bits.
      if (!src_fixed_q) src_d = src_q + WORD_STRIDE;
      if (!dst_fixed_q) dst_d = dst_q + WORD_STRIDE;
      remaining_d = remaining_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      src_fixed_q <= 1'b0;
      dst_fixed_q <= 1'b0;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      src_fixed_q <= src_fixed_d;
      dst_fixed_q <= dst_fixed_d;
    end
  end

  assign cur_src_o = src_q;
  assign cur_dst_o = dst_q;
  assign last_o    = (remaining_q == CNT_WIDTH'(1));

endmodule

// File: rtl/nanosoc_exp_dma_initiator.sv
// -----------------------------------------------------------------------------
// nanosoc_exp_dma_initiator
// AHB-Lite manager that copies 32-bit words from a source to a destination,
// one single-beat transfer outstanding at a time, paced by data_req.
//   HCLK, HRESETn        : clock, asynchronous active-low reset
//   start                : one-cycle job launch (ignored unless idle)
//   src_addr, dst_addr   : job byte addresses (low two bits ignored)
//   src_fixed, dst_fixed : hold the respective address constant (FIFO ports)
//   word_count           : words to copy; zero finishes immediately
//   data_req             : target ready for another word (sampled per word)
//   busy, done, error    : job in progress / end pulse / sticky bus error
//   HADDRM..HRDATAM      : AHB-Lite manager interface
// Handshake: an AHB phase (address or data) completes only on a rising edge
// where HREADYM=1; address/control and HWDATAM are held constant across every
// cycle with HREADYM=0, and HTRANSM leaves NONSEQ only after such an edge.
// The FSM state is kept in state_q for observation by bound checkers.
// -----------------------------------------------------------------------------
module nanosoc_exp_dma_initiator
  import nanosoc_exp_pkg::*;
#(
  parameter int         CNT_WIDTH = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic                 src_fixed,
  input  logic                 dst_fixed,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic                 data_req,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          HADDRM,
  output logic [1:0]           HTRANSM,
  output logic [2:0]           HSIZEM,
  output logic [2:0]           HBURSTM,
  output logic [3:0]           HPROTM,
  output logic                 HMASTLOCKM,
  output logic                 HWRITEM,
  output logic [31:0]          HWDATAM,
  input  logic                 HREADYM,
  input  logic                 HRESPM,
  input  logic [31:0]          HRDATAM
);

  dma_state_t  state_q, state_d;
  logic        error_q, error_d;
  logic [31:0] buf_q, buf_d;

  logic        load;
  logic        step;
  logic [31:0] cur_src;
  logic [31:0] cur_dst;
  logic        last_word;
  logic        data_phase;
  logic        phase_err;

  nanosoc_exp_dma_addr_gen #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_addr_gen (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .load_i      (load),
    .step_i      (step),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .src_fixed_i (src_fixed),
    .dst_fixed_i (dst_fixed),
    .count_i     (word_count),
    .cur_src_o   (cur_src),
    .cur_dst_o   (cur_dst),
    .last_o      (last_word)
  );

  assign data_phase = (state_q == ST_RD_DATA) || (state_q == ST_WR_DATA);
  // An error may be flagged in an earlier wait cycle of this data phase
  // (two-cycle error response) or on the completing cycle itself.
  assign phase_err  = error_q || HRESPM;

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    buf_d   = buf_q;
    load    = 1'b0;
    step    = 1'b0;
    HTRANSM = HTRANS_IDLE;
    HADDRM  = '0;
    HWRITEM = 1'b0;
    HWDATAM = '0;
    busy    = 1'b1;
    done    = 1'b0;

    if (data_phase && HRESPM) error_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          error_d = 1'b0;
          state_d = (word_count == '0) ? ST_FINISH : ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ: begin
        if (data_req) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        HTRANSM = HTRANS_NONSEQ;
        HADDRM  = cur_src;
        if (HREADYM) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (HREADYM) begin
          buf_d   = HRDATAM;
          // A failed read never turns into a write.
          state_d = phase_err ? ST_FINISH : ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        HTRANSM = HTRANS_NONSEQ;
        HADDRM  = cur_dst;
        HWRITEM = 1'b1;
        if (HREADYM) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        HWDATAM = buf_q;
        if (HREADYM) begin
          step    = 1'b1;
          state_d = (last_word || phase_err) ? ST_FINISH : ST_WAIT_REQ;
        end
      end
      ST_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      buf_q   <= buf_d;
    end
  end

  assign error      = error_q;
  assign HSIZEM     = HSIZE_WORD;
  assign HBURSTM    = HBURST_SINGLE;
  assign HPROTM     = HPROT_VAL;
  assign HMASTLOCKM = 1'b0;

endmodule

// File: tb/tb_nanosoc_exp_dma_initiator.sv
`timescale 1ns/1ps
module tb_nanosoc_exp_dma_initiator;

  // ---------------------------------------------------------------- clock/reset
  logic        HCLK = 1'b0;
  logic        HRESETn;
  always #5 HCLK = ~HCLK;

  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic        src_fixed, dst_fixed;
  logic [15:0] word_count;
  logic        data_req;
  logic        busy, done, error;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;
  logic        HMASTLOCKM, HWRITEM;
  logic [31:0] HWDATAM;
  logic        HREADYM, HRESPM;
  logic [31:0] HRDATAM;

  nanosoc_exp_dma_initiator #(
    .CNT_WIDTH (16),
    .HPROT_VAL (4'b0011)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .src_fixed  (src_fixed),
    .dst_fixed  (dst_fixed),
    .word_count (word_count),
    .data_req   (data_req),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .HADDRM     (HADDRM),
    .HTRANSM    (HTRANSM),
    .HSIZEM     (HSIZEM),
    .HBURSTM    (HBURSTM),
    .HPROTM     (HPROTM),
    .HMASTLOCKM (HMASTLOCKM),
    .HWRITEM    (HWRITEM),
    .HWDATAM    (HWDATAM),
    .HREADYM    (HREADYM),
    .HRESPM     (HRESPM),
    .HRDATAM    (HRDATAM)
  );

  // ---------------------------------------------------------------- checking
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfer log entries: {write, addr, data}; read entries carry data 0.
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    while (exp_q.size() > 0 && log_q.size() > 0)
      check(tag, log_q.pop_front(), exp_q.pop_front());
    log_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- AHB slave
  int          ws        = 0;   // wait states inserted in every phase
  int          err_rd    = -1;  // read index (within job) given an error
  int          rd_idx    = 0;
  int          wait_left = 0;
  bit          dp_active = 0, dp_write = 0, phase_new = 1, err_phase = 0;
  logic [31:0] dp_addr   = 0;
  logic [1:0]  prev_htrans = 0;
  logic [31:0] prev_haddr  = 0, prev_hwdata = 0;
  logic        prev_hwrite = 0, prev_hready = 1;

  // Runs at each falling edge: first retires what happened at the previous
  // rising edge (using the values held since the last falling edge), then
  // decides HREADYM/HRESPM/HRDATAM for the coming rising edge.
  task automatic slave_step();
    if (!HRESETn) begin
      dp_active = 0; wait_left = 0; phase_new = 1; err_phase = 0;
      prev_hready = 1; prev_htrans = 2'b00;
      HREADYM = 1; HRESPM = 0; HRDATAM = 0;
      return;
    end
    if (prev_hready) begin
      if (dp_active) begin
        log_q.push_back({dp_write, dp_addr, dp_write ? prev_hwdata : 32'h0});
        if (!dp_write) rd_idx++;
        dp_active = 0;
        err_phase = 0;
      end
      if (prev_htrans == 2'b10) begin
        dp_active = 1;
        dp_addr   = prev_haddr;
        dp_write  = prev_hwrite;
      end
      phase_new = 1;
    end else begin
      if (prev_htrans == 2'b10 && !dp_active) begin
        check("stall_htrans", HTRANSM, prev_htrans);
        check("stall_haddr", HADDRM, prev_haddr);
        check("stall_hwrite", HWRITEM, prev_hwrite);
      end
      if (dp_active && dp_write) check("stall_hwdata", HWDATAM, prev_hwdata);
    end
    if (phase_new && (dp_active || HTRANSM == 2'b10)) begin
      phase_new = 0;
      if (dp_active && !dp_write && rd_idx == err_rd) begin
        wait_left = 1;
        err_phase = 1;
      end else begin
        wait_left = ws;
      end
    end
    if (wait_left > 0) begin
      HREADYM = 0;
      wait_left--;
    end else begin
      HREADYM = 1;
    end
    HRESPM  = err_phase;
    HRDATAM = (dp_active && !dp_write) ? rdata(dp_addr) : 32'h0;
    prev_htrans = HTRANSM;
    prev_haddr  = HADDRM;
    prev_hwrite = HWRITEM;
    prev_hwdata = HWDATAM;
    prev_hready = HREADYM;
  endtask

  initial begin
    HREADYM = 1; HRESPM = 0; HRDATAM = 0;
    forever begin
      @(negedge HCLK);
      slave_step();
    end
  end

  // ---------------------------------------------------------------- drivers
  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic start_job(input logic [31:0] s, input logic [31:0] d,
                           input logic sf, input logic df, input logic [15:0] n);
    log_q.delete();
    rd_idx     = 0;
    src_addr   = s;
    dst_addr   = d;
    src_fixed  = sf;
    dst_fixed  = df;
    word_count = n;
    start      = 1;
    @(negedge HCLK);
    start = 0;
  endtask

  task automatic wait_done(inout int cyc, input int exp_cyc, input string tag);
    while (!done && cyc < 300) begin
      @(negedge HCLK);
      cyc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_busy_fin"}, busy, 0);
    @(negedge HCLK);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- tests
  int cyc;

  initial begin
    HRESETn = 0; start = 0; src_addr = 0; dst_addr = 0;
    src_fixed = 0; dst_fixed = 0; word_count = 0; data_req = 1;
    repeat (3) @(negedge HCLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_htrans", HTRANSM, 2'b00);
    check("rst_haddr", HADDRM, 32'h0);
    check("rst_hwrite", HWRITEM, 0);
    check("rst_hwdata", HWDATAM, 32'h0);
    check("hsize", HSIZEM, 3'b010);
    check("hburst", HBURSTM, 3'b000);
    check("hprot", HPROTM, 4'b0011);
    check("hmastlock", HMASTLOCKM, 0);
    HRESETn = 1;
    @(negedge HCLK);

    // Plain copy, 3 words, zero wait: done 16 cycles after start.
    start_job(32'h2000_0000, 32'h0001_0000, 0, 0, 3);
    cyc = 1;
    check("copy_busy", busy, 1);
    wait_done(cyc, 16, "copy");
    check("copy_error", error, 0);
    for (int i = 0; i < 3; i++) begin
      exp_rd(32'h2000_0000 + 32'(4 * i));
      exp_wr(32'h0001_0000 + 32'(4 * i), rdata(32'h2000_0000 + 32'(4 * i)));
    end
    compare_log("copy");

    // FIFO destination, unaligned source address gets aligned.
    start_job(32'h2000_0103, 32'h0001_0000, 0, 1, 4);
    cyc = 1;
    wait_done(cyc, 21, "fifo");
    for (int i = 0; i < 4; i++) begin
      exp_rd(32'h2000_0100 + 32'(4 * i));
      exp_wr(32'h0001_0000, rdata(32'h2000_0100 + 32'(4 * i)));
    end
    compare_log("fifo");

    // Three wait states in every phase: 17 cycles per word.
    ws = 3;
    start_job(32'h2000_0200, 32'h0001_0100, 0, 0, 2);
    cyc = 1;
    wait_done(cyc, 35, "wait");
    ws = 0;
    exp_rd(32'h2000_0200); exp_wr(32'h0001_0100, rdata(32'h2000_0200));
    exp_rd(32'h2000_0204); exp_wr(32'h0001_0104, rdata(32'h2000_0204));
    compare_log("wait");

    // Flow control: data_req drops mid word 1 (no effect), held low until
    // cycle 16; word 2 read issued in cycle 17.
    start_job(32'h2000_0300, 32'h0001_0200, 0, 0, 2);
    cyc = 1;
    @(negedge HCLK);
    cyc = 2;
    data_req = 0;
    for (int c = 3; c <= 16; c++) begin
      @(negedge HCLK);
      cyc = c;
      if (c >= 6) check("flow_idle", HTRANSM, 2'b00);
    end
    data_req = 1;
    @(negedge HCLK);
    cyc = 17;
    check("flow_trans", HTRANSM, 2'b10);
    check("flow_addr", HADDRM, 32'h2000_0304);
    check("flow_hwrite", HWRITEM, 0);
    wait_done(cyc, 21, "flow");
    exp_rd(32'h2000_0300); exp_wr(32'h0001_0200, rdata(32'h2000_0300));
    exp_rd(32'h2000_0304); exp_wr(32'h0001_0204, rdata(32'h2000_0304));
    compare_log("flow");

    // Two-cycle error response on the second read aborts the job.
    err_rd = 1;
    start_job(32'h2000_0400, 32'h0001_0300, 0, 0, 4);
    cyc = 1;
    wait_done(cyc, 10, "err");
    err_rd = -1;
    check("err_flag", error, 1);
    exp_rd(32'h2000_0400); exp_wr(32'h0001_0300, rdata(32'h2000_0400));
    exp_rd(32'h2000_0404);
    compare_log("err");
    repeat (4) @(negedge HCLK);
    check("err_sticky", error, 1);

    // Zero count, start held into the FINISH cycle: second start ignored.
    log_q.delete();
    src_addr = 32'h2000_0500; dst_addr = 32'h0001_0400; word_count = 0;
    start = 1;
    @(negedge HCLK);
    check("zero_done", done, 1);
    check("zero_err_clr", error, 0);
    check("zero_htrans", HTRANSM, 2'b00);
    @(negedge HCLK);
    start = 0;
    check("zero_ignored_busy", busy, 0);
    check("zero_ignored_done", done, 0);
    @(negedge HCLK);
    compare_log("zero");

    // Start while busy is ignored; latched job parameters are kept.
    start_job(32'h2000_0600, 32'h0001_0500, 0, 0, 2);
    cyc = 1;
    @(negedge HCLK); cyc = 2;
    @(negedge HCLK); cyc = 3;
    src_addr = 32'h3000_0000; dst_addr = 32'h0002_0000; word_count = 0; start = 1;
    @(negedge HCLK); cyc = 4;
    start = 0;
    wait_done(cyc, 11, "busy_start");
    exp_rd(32'h2000_0600); exp_wr(32'h0001_0500, rdata(32'h2000_0600));
    exp_rd(32'h2000_0604); exp_wr(32'h0001_0504, rdata(32'h2000_0604));
    compare_log("busy_start");

    // Source address wraps past the top of the map.
    start_job(32'hFFFF_FFFC, 32'h0001_0600, 0, 0, 2);
    cyc = 1;
    wait_done(cyc, 11, "wrap");
    exp_rd(32'hFFFF_FFFC); exp_wr(32'h0001_0600, rdata(32'hFFFF_FFFC));
    exp_rd(32'h0000_0000); exp_wr(32'h0001_0604, rdata(32'h0000_0000));
    compare_log("wrap");

    // Reset in the middle of word 2's read address phase.
    start_job(32'h2000_0700, 32'h0001_0700, 0, 0, 3);
    for (int c = 2; c <= 7; c++) @(negedge HCLK);
    check("pre_rst_htrans", HTRANSM, 2'b10);
    HRESETn = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_htrans", HTRANSM, 2'b00);
    check("mid_rst_haddr", HADDRM, 32'h0);
    check("mid_rst_hwrite", HWRITEM, 0);
    check("mid_rst_hwdata", HWDATAM, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      check("mid_rst_no_done", done, 0);
    end
    HRESETn = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      check("post_rst_no_done", done, 0);
    end

    // Single word after reset.
    start_job(32'h2000_0800, 32'h0001_0800, 0, 0, 1);
    cyc = 1;
    wait_done(cyc, 6, "post_rst");
    exp_rd(32'h2000_0800); exp_wr(32'h0001_0800, rdata(32'h2000_0800));
    compare_log("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
